// File: rtl/scytale_codec.sv
// Scytale encrypt/decrypt codec: buffers a message, then streams it column-wise with valid/ready backpressure.
// Optional macro SCYTALE_PAD_EN: emit the full key_N*key_M matrix, padding missing characters with PAD_CHAR.
module scytale_codec #(
    parameter int                 D_WIDTH       = 8,
    parameter int                 KEY_WIDTH     = 8,
    parameter int                 MAX_NOF_CHARS = 50,
    parameter logic [D_WIDTH-1:0] START_TOKEN   = 8'hFA,
    parameter logic [D_WIDTH-1:0] PAD_CHAR      = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 mode_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic                 err_o
);
    // Handshake: a character moves on input when valid_i && ready_o at posedge clk,
    // and on output when valid_o && ready_i; the output side holds data_o/last_o while stalled.

    localparam int AW = 2 * KEY_WIDTH + 1;
    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int IW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t             state_q, state_d;
    logic [D_WIDTH-1:0] buf_q [MAX_NOF_CHARS];
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [AW-1:0]      k_q, k_d, j_q, j_d, s_q, s_d, l_q, l_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic               buf_clr, buf_wr, load;
    logic [AW-1:0]      fetch_k, next_k, count_ext, tok_len;
    logic               tok_err;

    // True when index k in column j is the final one emitted for stride s and length l.
    function automatic logic is_last(input logic [AW-1:0] k, input logic [AW-1:0] j,
                                     input logic [AW-1:0] s, input logic [AW-1:0] l);
        logic [AW-1:0] j1;
        j1 = j + AW'(1);
        return ((k + s) >= l) && ((j1 >= s) || (j1 >= l));
    endfunction

    assign count_ext = AW'(count_q);
    assign next_k    = k_q + s_q;

`ifdef SCYTALE_PAD_EN
    logic [2*KEY_WIDTH-1:0] prod;
    assign prod    = {{KEY_WIDTH{1'b0}}, key_N} * {{KEY_WIDTH{1'b0}}, key_M};
    assign tok_len = {1'b0, prod};
    assign tok_err = ovf_q || (key_N == '0) || (key_M == '0) ||
                     (count_ext > tok_len) || (tok_len > AW'(MAX_NOF_CHARS));
`else
    assign tok_len = count_ext;
    assign tok_err = ovf_q || (key_N == '0) || (key_M == '0);
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        j_d     = j_q;
        s_d     = s_q;
        l_d     = l_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = 1'b0;
        buf_clr = 1'b0;
        buf_wr  = 1'b0;
        load    = 1'b0;
        fetch_k = '0;
        case (state_q)
            COLLECT: begin
                if (valid_i) begin
                    if (data_i != START_TOKEN) begin
                        if (count_q < CW'(MAX_NOF_CHARS)) begin
                            buf_wr  = 1'b1;
                            count_d = count_q + CW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (count_q != '0) begin
                        if (tok_err) begin
                            err_d   = 1'b1;
                            buf_clr = 1'b1;
                            count_d = '0;
                            ovf_d   = 1'b0;
                        end else begin
                            s_d     = mode_i ? AW'(key_M) : AW'(key_N);
                            l_d     = tok_len;
                            k_d     = '0;
                            j_d     = '0;
                            load    = 1'b1;
                            valid_d = 1'b1;
                            last_d  = is_last('0, '0, s_d, l_d);
                            state_d = EMIT;
                        end
                    end
                end
            end
            EMIT: begin
                if (valid_q && ready_i) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = COLLECT;
                    end else begin
                        // Column exhausted: the last-index test guarantees column j+1 exists.
                        if (next_k < l_q) begin
                            k_d = next_k;
                        end else begin
                            k_d = j_q + AW'(1);
                            j_d = j_q + AW'(1);
                        end
                        fetch_k = k_d;
                        load    = 1'b1;
                        last_d  = is_last(k_d, j_d, s_q, l_q);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
        if (load) begin
            data_d = (fetch_k < count_ext) ? buf_q[fetch_k[IW-1:0]] : PAD_CHAR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            count_q <= '0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            j_q     <= '0;
            s_q     <= '0;
            l_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
            j_q     <= j_d;
            s_q     <= s_d;
            l_q     <= l_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || buf_clr) begin
            for (int i = 0; i < MAX_NOF_CHARS; i++) buf_q[i] <= '0;
        end else if (buf_wr) begin
            buf_q[count_q[IW-1:0]] <= data_i;
        end
    end

    assign ready_o = (state_q == COLLECT);
    assign busy    = (state_q == EMIT);
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_scytale_codec.sv
// Directed scoreboard bench for scytale_codec: expected {last,char} pairs queued by stimulus, popped by a monitor.
module tb_scytale_codec;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       mode_i;
    logic [7:0] key_N;
    logic [7:0] key_M;
    logic       busy;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       last_o;
    logic       err_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       hold_pending = 1'b0;
    logic [8:0] hold_val;

    scytale_codec dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .mode_i(mode_i), .key_N(key_N), .key_M(key_M), .busy(busy), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        valid_i = 1'b1;
        data_i  = c;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic send_msg(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic send_tok(input logic m, input logic [7:0] n, input logic [7:0] r);
        mode_i = m;
        key_N  = n;
        key_M  = r;
        send(8'hFA);
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({(i == s.len() - 1), s[i]});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain"}, (exp_q.size() == 0 && !busy), 1);
    endtask

    // Monitor: checks stability under stall and pops the scoreboard on every transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_pending) begin
                check("hold_valid", valid_o, 1);
                check("hold_data", {last_o, data_o}, hold_val);
            end
            hold_pending = 1'b0;
            if (valid_o && !ready_i) begin
                hold_pending = 1'b1;
                hold_val     = {last_o, data_o};
            end else if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {last_o, data_o}, 9'h1ff);
                end else begin
                    check("out_char", {last_o, data_o}, exp_q.pop_front());
                    rx_q.push_back(data_o);
                end
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string fb;
        rst = 1'b1; data_i = '0; valid_i = 1'b0; mode_i = 1'b0;
        key_N = 8'd2; key_M = 8'd3; ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_last", last_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ready", ready_o, 1);

        // Decrypt at full throughput
        send_msg("ADBECF");
        expect_str("ABCDEF");
        send_tok(1'b0, 8'd2, 8'd3);
        check("dec_busy", busy, 1);
        check("dec_valid_first", valid_o, 1);
        check("dec_ready_low", ready_o, 0);
        repeat (6) @(posedge clk);
        #1;
        check("dec_done_busy", busy, 0);
        check("dec_done_valid", valid_o, 0);
        check("dec_done_ready", ready_o, 1);
        check("dec_consecutive", exp_q.size(), 0);

        // Encrypt, then decrypt the captured ciphertext
        rx_q.delete();
        send_msg("ABCDEF");
        expect_str("ADBECF");
        send_tok(1'b1, 8'd2, 8'd3);
        wait_drain("enc");
        fb = "";
        while (rx_q.size() != 0) fb = {fb, string'(rx_q.pop_front())};
        check("enc_len", fb.len(), 6);
        send_msg(fb);
        expect_str("ABCDEF");
        send_tok(1'b0, 8'd2, 8'd3);
        wait_drain("roundtrip");

        // Backpressure on the second character
        send_msg("ADBECF");
        expect_str("ABCDEF");
        send_tok(1'b0, 8'd2, 8'd3);
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_held_char", data_o, 8'h42);
        ready_i = 1'b1;
        wait_drain("bp");

        // Overflow
        for (int i = 0; i < 51; i++) send(8'h61);
        send_tok(1'b0, 8'd2, 8'd3);
        check("ovf_err", err_o, 1);
        check("ovf_valid", valid_o, 0);
        check("ovf_ready", ready_o, 1);
        check("ovf_busy", busy, 0);
        @(posedge clk);
        #1;
        check("ovf_err_pulse", err_o, 0);

        // Zero key
        send_msg("ABC");
        send_tok(1'b0, 8'd0, 8'd3);
        check("zkey_err", err_o, 1);
        check("zkey_valid", valid_o, 0);
        check("zkey_ready", ready_o, 1);
        @(posedge clk);
        #1;
        check("zkey_err_pulse", err_o, 0);

        // Partial matrix
        send_msg("ADBEC");
`ifdef SCYTALE_PAD_EN
        expect_str({"ABCDE", string'(8'h00)});
`else
        expect_str("ABCDE");
`endif
        send_tok(1'b0, 8'd2, 8'd3);
        wait_drain("partial");

        // Reset mid-emission
        send_msg("ADBECF");
        expect_str("ABCDEF");
        send_tok(1'b0, 8'd2, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("midrst_valid", valid_o, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready_o, 1);
        send_msg("ADBECF");
        expect_str("ABCDEF");
        send_tok(1'b0, 8'd2, 8'd3);
        wait_drain("after_rst");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
